// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA bus-master: widths, burst geometry and FSM encodings.
// The CPU grant logic imports the same package so both ends agree on the grant window.
package dma_controller_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int BURST_WORDS  = 4;
    localparam int FETCH_SIZE   = BURST_WORDS * WORD_SIZE;
    localparam int NUM_BURSTS   = 3;
    localparam int BURST_CYCLES = 4;
    localparam int GRANT_CYCLES = NUM_BURSTS * BURST_CYCLES;
    localparam int LINE_W       = 2;
    localparam int CYC_W        = 2;

    // ST_BACKOFF keeps BR low for one cycle after the CPU revokes the bus.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_DONE    = 3'd3,
        ST_BACKOFF = 3'd4
    } dma_state_t;

    // Destination word address of a line; wraps modulo 2^WORD_SIZE.
    function automatic logic [WORD_SIZE-1:0] line_address(
        input logic [WORD_SIZE-1:0] base,
        input logic [LINE_W-1:0]    line
    );
        logic [WORD_SIZE-1:0] offset;
        offset = WORD_SIZE'(line) * WORD_SIZE'(BURST_WORDS);
        return base + offset;
    endfunction

endpackage

// File: rtl/dma_controller_burst_counter.sv
// Cycle-within-line and line counters for the DMA transfer, with end-of-transfer flag.
module dma_burst_counter
    import dma_controller_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              start,
    input  logic              restart,
    input  logic              step,
    output logic [LINE_W-1:0] line,
    output logic              xfer_done
);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BURST_CYCLES - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_BURSTS - 1);

    logic [CYC_W-1:0] cyc_r;

    assign xfer_done = (cyc_r == CYC_LAST) && (line == LINE_LAST);

    // Restart drops only the cycle count so an aborted line is rewritten in full.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cyc_r <= {CYC_W{1'b0}};
            line  <= {LINE_W{1'b0}};
        end else if (start) begin
            cyc_r <= {CYC_W{1'b0}};
            line  <= {LINE_W{1'b0}};
        end else if (restart) begin
            cyc_r <= {CYC_W{1'b0}};
        end else if (step) begin
            if (cyc_r == CYC_LAST) begin
                cyc_r <= {CYC_W{1'b0}};
                line  <= (line == LINE_LAST) ? {LINE_W{1'b0}} : line + LINE_W'(1);
            end else begin
                cyc_r <= cyc_r + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/dma_controller.sv
// DMA bus master: requests the bus, writes NUM_BURSTS device lines to memory, then
// releases the bus and pulses dma_end. Yields immediately if the CPU drops BG.
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  cmd,
    input  logic [WORD_SIZE-1:0]  dma_base,
    input  logic [FETCH_SIZE-1:0] dev_data,
    output logic [LINE_W-1:0]     dev_line,
    input  logic                  BG,
    output logic                  BR,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [FETCH_SIZE-1:0] d_data,
    output logic                  d_writeM,
    output logic                  d_oe,
    output logic                  dma_end
);

    dma_state_t           state_r;
    logic [WORD_SIZE-1:0] base_r;
    logic [LINE_W-1:0]    line_s;
    logic                 xfer_done_s;
    logic                 cnt_start_s;
    logic                 cnt_restart_s;
    logic                 cnt_step_s;
    logic                 drive_s;

    dma_burst_counter u_counter (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .start     (cnt_start_s),
        .restart   (cnt_restart_s),
        .step      (cnt_step_s),
        .line      (line_s),
        .xfer_done (xfer_done_s)
    );

    // Counter control and bus drive; drive follows BG combinationally so a revoke aborts at once.
    always_comb begin
        cnt_start_s   = 1'b0;
        cnt_restart_s = 1'b0;
        cnt_step_s    = 1'b0;
        drive_s       = 1'b0;
        if (state_r == ST_XFER) begin
            drive_s    = BG;
            cnt_step_s = BG;
        end else if (state_r == ST_IDLE) begin
            cnt_start_s = cmd;
        end else begin
            cnt_restart_s = 1'b1;
        end
    end

    // Bus-side outputs are forced to zero whenever the DMA is not driving.
    always_comb begin
        d_oe     = drive_s;
        d_writeM = drive_s;
        dev_line = line_s;
        if (drive_s) begin
            d_address = line_address(base_r, line_s);
            d_data    = dev_data;
        end else begin
            d_address = {WORD_SIZE{1'b0}};
            d_data    = {FETCH_SIZE{1'b0}};
        end
    end

    // Handshake FSM with registered BR and dma_end.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r <= ST_IDLE;
            base_r  <= {WORD_SIZE{1'b0}};
            BR      <= 1'b0;
            dma_end <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dma_end <= 1'b0;
                    if (cmd) begin
                        base_r  <= dma_base;
                        BR      <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (BG) begin
                        state_r <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!BG) begin
                        BR      <= 1'b0;
                        state_r <= ST_BACKOFF;
                    end else if (xfer_done_s) begin
                        BR      <= 1'b0;
                        dma_end <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dma_end <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_BACKOFF: begin
                    BR      <= 1'b1;
                    state_r <= ST_REQ;
                end
                default: begin
                    BR      <= 1'b0;
                    dma_end <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: the bench plays the CPU side (cmd, BG) and a device
// buffer whose line n holds 64'h0001_0002_0003_0004 + n.
module tb_dma_controller;

    logic        Clk;
    logic        Reset_N;
    logic        cmd;
    logic [15:0] dma_base;
    logic [63:0] dev_data;
    logic [1:0]  dev_line;
    logic        BG;
    logic        BR;
    logic [15:0] d_address;
    logic [63:0] d_data;
    logic        d_writeM;
    logic        d_oe;
    logic        dma_end;

    int n_compared;
    int n_mismatched;

    localparam logic [63:0] DEV_BASE = 64'h0001_0002_0003_0004;

    dma_controller dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .cmd       (cmd),
        .dma_base  (dma_base),
        .dev_data  (dev_data),
        .dev_line  (dev_line),
        .BG        (BG),
        .BR        (BR),
        .d_address (d_address),
        .d_data    (d_data),
        .d_writeM  (d_writeM),
        .d_oe      (d_oe),
        .dma_end   (dma_end)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Device buffer indexed by the DUT's line select.
    assign dev_data = DEV_BASE + {62'd0, dev_line};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One transfer. skip_cmd: DUT already in REQ. hold_cmd: leave cmd high.
    // drop_at / rst_at: granted cycle at which BG is revoked / reset asserted (-1 = never).
    task automatic run_xfer(input logic [15:0] base, input bit skip_cmd, input bit hold_cmd,
                            input int drop_at, input int rst_at);
        int g;
        int line;
        int cyc;
        logic [15:0] exp_addr;
        if (!skip_cmd) begin
            cmd      = 1'b1;
            dma_base = base;
            tick();
            if (!hold_cmd) cmd = 1'b0;
            check_eq("br_rise", 64'(BR), 64'd1);
        end else begin
            cmd = 1'b0;
        end
        check_eq("no_drive_in_req", 64'(d_oe), 64'd0);
        tick();
        BG = 1'b1;
        check_eq("no_write_before_grant_edge", 64'(d_writeM), 64'd0);
        tick();
        line = 0;
        cyc  = 0;
        g    = 0;
        while (line < 3) begin
            exp_addr = base + 16'(4 * line);
            check_eq("wr", 64'(d_writeM), 64'd1);
            check_eq("oe", 64'(d_oe), 64'd1);
            check_eq("addr", 64'(d_address), 64'(exp_addr));
            check_eq("data", d_data, DEV_BASE + 64'(line));
            check_eq("dev_line", 64'(dev_line), 64'(line));
            check_eq("br_held", 64'(BR), 64'd1);
            if (g == rst_at) begin
                Reset_N = 1'b0;
                #1;
                check_eq("rst_br", 64'(BR), 64'd0);
                check_eq("rst_oe", 64'(d_oe), 64'd0);
                check_eq("rst_wr", 64'(d_writeM), 64'd0);
                BG = 1'b0;
                tick();
                check_eq("rst_no_end", 64'(dma_end), 64'd0);
                Reset_N = 1'b1;
                tick();
                check_eq("rst_no_end2", 64'(dma_end), 64'd0);
                check_eq("rst_br_idle", 64'(BR), 64'd0);
                return;
            end
            if (g == drop_at) begin
                drop_at = -1;
                BG = 1'b0;
                #1;
                check_eq("abort_wr", 64'(d_writeM), 64'd0);
                check_eq("abort_oe", 64'(d_oe), 64'd0);
                tick();
                check_eq("backoff_br_low", 64'(BR), 64'd0);
                tick();
                check_eq("rerequest_br", 64'(BR), 64'd1);
                tick();
                BG = 1'b1;
                tick();
                cyc = 0;
                continue;
            end
            tick();
            g++;
            cyc++;
            if (cyc == 4) begin
                cyc = 0;
                line++;
            end
        end
        BG = 1'b0;
        check_eq("end_pulse", 64'(dma_end), 64'd1);
        check_eq("br_released", 64'(BR), 64'd0);
        check_eq("wr_done_low", 64'(d_writeM), 64'd0);
        tick();
        check_eq("end_one_cycle", 64'(dma_end), 64'd0);
        check_eq("br_idle", 64'(BR), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        Reset_N  = 1'b0;
        cmd      = 1'b0;
        dma_base = 16'h0000;
        BG       = 1'b0;
        #23;
        check_eq("reset_br", 64'(BR), 64'd0);
        check_eq("reset_oe", 64'(d_oe), 64'd0);
        check_eq("reset_wr", 64'(d_writeM), 64'd0);
        check_eq("reset_end", 64'(dma_end), 64'd0);
        check_eq("reset_line", 64'(dev_line), 64'd0);
        check_eq("reset_addr", 64'(d_address), 64'd0);
        tick();
        Reset_N = 1'b1;
        tick();

        // Plain transfer plus per-line data
        run_xfer(16'h01F4, 1'b0, 1'b0, -1, -1);
        tick();
        check_eq("idle_stays_quiet", 64'(BR), 64'd0);

        // Preempted at granted cycle 6 (line 1, cycle 2)
        run_xfer(16'h01F4, 1'b0, 1'b0, 6, -1);

        // Reset at granted cycle 5, then a fresh transfer from line 0
        run_xfer(16'h01F4, 1'b0, 1'b0, -1, 5);
        run_xfer(16'h0300, 1'b0, 1'b0, -1, -1);

        // Address wrap
        run_xfer(16'hFFFC, 1'b0, 1'b0, -1, -1);

        // cmd held high: one transfer per IDLE visit
        run_xfer(16'h0040, 1'b0, 1'b1, -1, -1);
        tick();
        check_eq("retrigger_after_idle", 64'(BR), 64'd1);
        run_xfer(16'h0040, 1'b1, 1'b0, -1, -1);
        tick();
        check_eq("no_extra_transfer", 64'(BR), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
